// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: fetch, decode, execute, memory, write-back.
// One shared memory port; outputs decode from state and latched opcode.
module multicycle_ctrl #(
  parameter int OPW  = 4,
  parameter int ALUW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OPW-1:0]  opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic [1:0]      pc_src,
  output logic            ir_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            iord,
  output logic            reg_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic [1:0]      alu_src_b,
  output logic [ALUW-1:0] alu_op,
  output logic            out_load,
  output logic            illegal,
  output logic            halted,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [OPW-1:0] OP_NOP  = OPW'(0);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(1);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(2);
  localparam logic [OPW-1:0] OP_AND  = OPW'(3);
  localparam logic [OPW-1:0] OP_OR   = OPW'(4);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(5);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6);
  localparam logic [OPW-1:0] OP_SW   = OPW'(7);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(8);
  localparam logic [OPW-1:0] OP_J    = OPW'(9);
  localparam logic [OPW-1:0] OP_OUT  = OPW'(10);
  localparam logic [OPW-1:0] OP_HALT = OPW'(15);

  localparam logic [ALUW-1:0] ALU_ADD = ALUW'(0);
  localparam logic [ALUW-1:0] ALU_SUB = ALUW'(1);
  localparam logic [ALUW-1:0] ALU_AND = ALUW'(2);
  localparam logic [ALUW-1:0] ALU_OR  = ALUW'(3);

  state_t         st;
  logic [OPW-1:0] op_q;

  function automatic logic is_rtype(input logic [OPW-1:0] o);
    return (o == OP_ADD) || (o == OP_SUB) ||
           (o == OP_AND) || (o == OP_OR);
  endfunction

  function automatic logic is_legal(input logic [OPW-1:0] o);
    return (o <= OP_OUT) || (o == OP_HALT);
  endfunction

  // NOP, J and undefined opcodes all retire in DECODE
  function automatic logic ends_in_decode(input logic [OPW-1:0] o);
    return (o == OP_NOP) || (o == OP_J) || !is_legal(o);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= S_FETCH;
      op_q <= '0;
    end else begin
      unique case (st)
        S_FETCH: begin
          if (mem_ready) st <= S_DECODE;
        end
        S_DECODE: begin
          op_q <= opcode;
          if (ends_in_decode(opcode))  st <= S_FETCH;
          else if (opcode == OP_HALT)  st <= S_HALT;
          else                         st <= S_EXEC;
        end
        S_EXEC: begin
          if (is_rtype(op_q) || op_q == OP_ADDI)
            st <= S_WB;
          else if (op_q == OP_LW || op_q == OP_SW)
            st <= S_MEM;
          else
            st <= S_FETCH;
        end
        S_MEM: begin
          if (mem_ready)
            st <= (op_q == OP_LW) ? S_WB : S_FETCH;
        end
        S_WB:    st <= S_FETCH;
        S_HALT:  st <= S_HALT;
        default: st <= S_FETCH;
      endcase
    end
  end

  assign state = st;

  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    out_load   = 1'b0;
    illegal    = 1'b0;
    halted     = 1'b0;
    // reset masks outputs asynchronously, not just at the next edge
    if (rst_n) begin
      unique case (st)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_DECODE: begin
          illegal = !is_legal(opcode);
          if (opcode == OP_J) begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
          end
        end
        S_EXEC: begin
          unique case (1'b1)
            (op_q == OP_SUB): alu_op = ALU_SUB;
            (op_q == OP_AND): alu_op = ALU_AND;
            (op_q == OP_OR):  alu_op = ALU_OR;
            (op_q == OP_BEQ): begin
              alu_op = ALU_SUB;
              if (zero) begin
                pc_write = 1'b1;
                pc_src   = 2'b01;
              end
            end
            (op_q == OP_ADDI || op_q == OP_LW || op_q == OP_SW):
              alu_src_b = 2'b10;
            (op_q == OP_OUT): out_load = 1'b1;
            default: ;
          endcase
        end
        S_MEM: begin
          iord      = 1'b1;
          mem_read  = (op_q == OP_LW);
          mem_write = (op_q == OP_SW);
        end
        S_WB: begin
          reg_write  = 1'b1;
          reg_dst    = is_rtype(op_q);
          mem_to_reg = (op_q == OP_LW);
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: per-cycle trace model of each instruction
// built from opcode class and memory wait counts, with randomized side inputs.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       out_load;
  logic       illegal;
  logic       halted;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.OPW(4), .ALUW(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .out_load(out_load), .illegal(illegal), .halted(halted),
    .state(state)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       mr, mw, io, irw, pcw;
    logic [1:0] pcs;
    logic       rw, rd, m2r;
    logic [1:0] asb;
    logic [2:0] aop;
    logic       ol, ill, hlt;
  } rec_t;

  rec_t obs;
  always_comb begin
    obs     = '0;
    obs.st  = state;
    obs.mr  = mem_read;
    obs.mw  = mem_write;
    obs.io  = iord;
    obs.irw = ir_write;
    obs.pcw = pc_write;
    obs.pcs = pc_src;
    obs.rw  = reg_write;
    obs.rd  = reg_dst;
    obs.m2r = mem_to_reg;
    obs.asb = alu_src_b;
    obs.aop = alu_op;
    obs.ol  = out_load;
    obs.ill = illegal;
    obs.hlt = halted;
  end

  int   q_rdy[$];
  int   q_op[$];
  int   q_z[$];
  rec_t q_exp[$];

  function automatic int rnd_bit();
    return int'($urandom_range(0, 1));
  endfunction

  function automatic int fill(input int post_op);
    return (post_op < 0) ? int'($urandom_range(0, 15)) : post_op;
  endfunction

  task automatic push(input int r, input int o, input int z, input rec_t e);
    q_rdy.push_back(r);
    q_op.push_back(o);
    q_z.push_back(z);
    q_exp.push_back(e);
  endtask

  // Expected cycle trace of one instruction: opcode class decides the
  // phase list, wait counts stretch FETCH and MEM.
  task automatic gen(input int op, input int fw, input int mwt,
                     input int z, input int post_op, input int halt_n);
    rec_t e;
    for (int i = 0; i <= fw; i++) begin
      e = '0; e.st = 3'd0; e.mr = 1; e.asb = 2'b01;
      if (i == fw) begin e.irw = 1; e.pcw = 1; end
      push(i == fw, fill(post_op), rnd_bit(), e);
    end
    e = '0; e.st = 3'd1;
    if (op == 9) begin e.pcw = 1; e.pcs = 2'b10; end
    if (op >= 11 && op <= 14) e.ill = 1;
    push(rnd_bit(), op, rnd_bit(), e);
    if (op == 0 || op == 9 || (op >= 11 && op <= 14)) return;
    if (op == 15) begin
      for (int i = 0; i < halt_n; i++) begin
        e = '0; e.st = 3'd5; e.hlt = 1;
        push(rnd_bit(), fill(post_op), rnd_bit(), e);
      end
      return;
    end
    e = '0; e.st = 3'd2;
    if (op >= 1 && op <= 4) e.aop = 3'(op - 1);
    if (op >= 5 && op <= 7) e.asb = 2'b10;
    if (op == 8) begin
      e.aop = 3'd1;
      if (z != 0) begin e.pcw = 1; e.pcs = 2'b01; end
    end
    if (op == 10) e.ol = 1;
    push(rnd_bit(), fill(post_op), z, e);
    if (op == 8 || op == 10) return;
    if (op == 6 || op == 7) begin
      for (int i = 0; i <= mwt; i++) begin
        e = '0; e.st = 3'd3; e.io = 1;
        e.mr = (op == 6); e.mw = (op == 7);
        push(i == mwt, fill(post_op), rnd_bit(), e);
      end
      if (op == 7) return;
    end
    e = '0; e.st = 3'd4; e.rw = 1;
    e.rd = (op <= 4); e.m2r = (op == 6);
    push(rnd_bit(), fill(post_op), rnd_bit(), e);
  endtask

  // Entered and left on a falling edge; checks each cycle before its rising edge.
  task automatic apply(input string name, input int maxc);
    int n;
    n = (q_exp.size() < maxc) ? q_exp.size() : maxc;
    for (int i = 0; i < n; i++) begin
      mem_ready = q_rdy[i][0];
      opcode    = 4'(q_op[i]);
      zero      = q_z[i][0];
      #1;
      checks++;
      if (obs !== q_exp[i]) begin
        errors++;
        $display("FAIL %s cyc%0d: got %h want %h", name, i, obs, q_exp[i]);
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    q_rdy.delete(); q_op.delete(); q_z.delete(); q_exp.delete();
  endtask

  task automatic do_reset();
    mem_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 4'd6; zero = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (obs !== rec_t'(0)) begin
      errors++;
      $display("FAIL reset_outputs: got %h want %h", obs, rec_t'(0));
    end
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    gen(1, 0, 0, 0, -1, 0);
    apply("add", 1000);
  endtask

  task automatic test_lw_wait();
    gen(6, 3, 2, rnd_bit(), -1, 0);
    checks++;
    if (q_exp.size() != 10) begin
      errors++;
      $display("FAIL lw_len: got %0d want 10", q_exp.size());
    end
    apply("lw_wait", 1000);
  endtask

  task automatic test_beq();
    gen(8, 0, 0, 1, -1, 0);
    apply("beq_taken", 1000);
    gen(8, 0, 0, 0, -1, 0);
    apply("beq_not", 1000);
  endtask

  task automatic test_sequence();
    gen(9, 0, 0, rnd_bit(), -1, 0);
    apply("j", 1000);
    gen(10, 1, 0, rnd_bit(), -1, 0);
    apply("out", 1000);
    gen(12, 0, 0, rnd_bit(), -1, 0);
    apply("illegal_c", 1000);
    gen(15, 0, 0, rnd_bit(), -1, 24);
    apply("halt", 1000);
    do_reset();
  endtask

  task automatic test_async_reset();
    gen(7, 0, 5, rnd_bit(), -1, 0);
    apply("sw_pre", 4);
    mem_ready = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b1 || state !== 3'd3) begin
      errors++;
      $display("FAIL sw_in_mem: got mw=%b st=%0d want mw=1 st=3",
               mem_write, state);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== rec_t'(0)) begin
      errors++;
      $display("FAIL async_reset: got %h want %h", obs, rec_t'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    gen(0, 0, 0, rnd_bit(), -1, 0);
    apply("after_reset", 1000);
  endtask

  task automatic test_opcode_change();
    gen(1, 0, 0, rnd_bit(), 6, 0);
    apply("add_op6", 1000);
  endtask

  task automatic test_back_to_back();
    int op;
    for (int k = 0; k < 40; k++) begin
      op = int'($urandom_range(0, 14));
      gen(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          rnd_bit(), -1, 0);
      apply("random", 1000);
    end
  endtask

  initial begin
    rst_n = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_add();
    test_lw_wait();
    test_beq();
    test_sequence();
    test_async_reset();
    test_opcode_change();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
